// File: rtl/pack_gen.sv
// pack_gen: turns a raw vs/hs/de/rgb pixel stream into the 49-bit pixel pack
// {vs, hs, de, rgb, x, y, sof}. It tags each pixel with its coordinates, checks
// frame geometry against H_ACT x V_ACT, and gates active video until lock.
module pack_gen #(
  parameter int   H_ACT       = 1280,
  parameter int   V_ACT       = 720,
  parameter logic VS_POL      = 1'b1,
  parameter logic HS_POL      = 1'b1,
  parameter int   LOCK_FRAMES = 2,
  parameter int   XW          = $clog2(H_ACT),
  parameter int   YW          = $clog2(V_ACT),
  localparam int  PW          = 28 + XW + YW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_vs,
  input  logic          i_hs,
  input  logic          i_de,
  input  logic [23:0]   i_rgb,
  output logic [PW-1:0] o_pack,
  output logic          locked,
  output logic          frame_err,
  output logic [7:0]    err_cnt
);

  localparam logic [XW-1:0] X_MAX     = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(V_ACT - 1);
  localparam logic [11:0]   LEN_EXP   = 12'(H_ACT);
  localparam logic [10:0]   LINES_EXP = 11'(V_ACT);
  localparam logic [3:0]    LOCK_N    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    CHECK   = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage 0: normalised input samples plus one-cycle history for edge detection
  // ---------------------------------------------------------------------------
  logic        vs_s0_q, hs_s0_q, de_s0_q;
  logic [23:0] rgb_s0_q;
  logic        vs_prev_q, de_prev_q;

  // Register the inputs once with syncs flipped to active-high, and keep history
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_s0_q   <= 1'b0;
      hs_s0_q   <= 1'b0;
      de_s0_q   <= 1'b0;
      rgb_s0_q  <= '0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      vs_s0_q   <= i_vs ~^ VS_POL;
      hs_s0_q   <= i_hs ~^ HS_POL;
      de_s0_q   <= i_de;
      rgb_s0_q  <= i_rgb;
      vs_prev_q <= vs_s0_q;
      de_prev_q <= de_s0_q;
    end
  end

  logic frame_start, line_start, line_end;
  assign frame_start = vs_s0_q & ~vs_prev_q;
  assign line_start  = de_s0_q & ~de_prev_q;
  assign line_end    = ~de_s0_q & de_prev_q;

  // ---------------------------------------------------------------------------
  // Pixel / line counters and geometry tracking
  // ---------------------------------------------------------------------------
  logic [XW-1:0] x_q, x_d, x_cur;
  logic [11:0]   len_q, len_d, len_cur;
  logic [YW-1:0] y_q, y_d, y_inc, y_cur;
  logic [10:0]   line_cnt_q, line_cnt_d, lines_eff;
  logic          bad_q, bad_d, bad_eff, line_bad;
  logic          frame_good;

  // Counter next-state: a line end is folded into the old frame before a
  // coincident frame start evaluates and clears it
  always_comb begin
    x_cur      = line_start ? '0 : x_q;
    len_cur    = line_start ? '0 : len_q;
    x_d        = x_q;
    len_d      = len_q;
    lines_eff  = line_cnt_q;
    y_inc      = y_q;
    y_d        = y_q;
    line_cnt_d = line_cnt_q;
    bad_d      = bad_q;
    y_cur      = frame_start ? '0 : y_q;

    if (de_s0_q) begin
      x_d   = (x_cur == X_MAX) ? x_cur : x_cur + XW'(1);
      len_d = (len_cur == 12'hFFF) ? len_cur : len_cur + 12'd1;
    end

    line_bad = line_end && (len_q != LEN_EXP);
    bad_eff  = bad_q | line_bad;
    if (line_end) begin
      if (line_cnt_q != 11'h7FF) lines_eff = line_cnt_q + 11'd1;
      if (y_q != Y_MAX)          y_inc     = y_q + YW'(1);
    end
    frame_good = !bad_eff && (lines_eff == LINES_EXP);

    if (frame_start) begin
      y_d        = '0;
      line_cnt_d = '0;
      bad_d      = 1'b0;
    end else begin
      y_d        = y_inc;
      line_cnt_d = lines_eff;
      bad_d      = bad_eff;
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_q        <= '0;
      len_q      <= '0;
      y_q        <= '0;
      line_cnt_q <= '0;
      bad_q      <= 1'b0;
    end else begin
      x_q        <= x_d;
      len_q      <= len_d;
      y_q        <= y_d;
      line_cnt_q <= line_cnt_d;
      bad_q      <= bad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock state machine: every transition happens on a frame start
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        err_pulse;
  logic        locked_d;
  logic [7:0]  err_cnt_d;

  // Next-state logic: count good frames toward lock, drop lock on any bad frame
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_pulse  = 1'b0;
    case (state_q)
      WAIT_VS: begin
        if (frame_start) begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
      end
      CHECK: begin
        if (frame_start) begin
          if (frame_good) begin
            if (good_cnt_q + 4'd1 >= LOCK_N) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            good_cnt_d = '0;
            err_pulse  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (frame_start && !frame_good) begin
          state_d    = CHECK;
          good_cnt_d = '0;
          err_pulse  = 1'b1;
        end
      end
      default: begin
        state_d    = WAIT_VS;
        good_cnt_d = '0;
      end
    endcase
    locked_d  = (state_d == LOCKED);
    err_cnt_d = (err_pulse && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
  end

  // State, lock flag and error bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= WAIT_VS;
      good_cnt_q <= '0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      locked     <= locked_d;
      frame_err  <= err_pulse;
      err_cnt    <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: output pack. Gating uses the lock value being registered this
  // cycle, so the frame whose start causes lock is the first one emitted.
  // ---------------------------------------------------------------------------
  logic          de_g, sof;
  logic [PW-1:0] pack_d;

  // Assemble the pack; rgb and coordinates are zeroed outside gated video
  always_comb begin
    de_g   = de_s0_q & locked_d;
    sof    = de_g && (x_cur == '0) && (y_cur == '0);
    pack_d = {vs_s0_q, hs_s0_q, de_g,
              de_g ? rgb_s0_q : 24'd0,
              de_g ? x_cur : {XW{1'b0}},
              de_g ? y_cur : {YW{1'b0}},
              sof};
  end

  // Output pack register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_pack <= '0;
    end else begin
      o_pack <= pack_d;
    end
  end

endmodule

// File: tb/tb_pack_gen.sv
// Bench for pack_gen with a small 16x6 geometry. Two instances run side by side,
// one with active-high syncs and one with active-low syncs fed inverted inputs;
// both are checked every cycle against a frame-rule reference model, plus a
// table of frame records and hand-written corner sequences.
module tb_pack_gen;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int LK = 2;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam int PW = 28 + XW + YW;

  logic          clk;
  logic          rstn;
  logic          vs, hs, de;
  logic [23:0]   rgb;
  logic [PW-1:0] pack_p, pack_n;
  logic          lk_p, lk_n, fe_p, fe_n;
  logic [7:0]    ec_p, ec_n;

  pack_gen #(.H_ACT(H), .V_ACT(V), .VS_POL(1'b1), .HS_POL(1'b1), .LOCK_FRAMES(LK)) dut (
    .clk(clk), .rstn(rstn), .i_vs(vs), .i_hs(hs), .i_de(de), .i_rgb(rgb),
    .o_pack(pack_p), .locked(lk_p), .frame_err(fe_p), .err_cnt(ec_p)
  );

  pack_gen #(.H_ACT(H), .V_ACT(V), .VS_POL(1'b0), .HS_POL(1'b0), .LOCK_FRAMES(LK)) dut_n (
    .clk(clk), .rstn(rstn), .i_vs(~vs), .i_hs(~hs), .i_de(de), .i_rgb(rgb),
    .o_pack(pack_n), .locked(lk_n), .frame_err(fe_n), .err_cnt(ec_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_seen = 0;
  int sof_seen = 0;

  // Reference model state (integers, unsaturated where harmless)
  bit          s0_vs, s0_hs, s0_de, p_vs, p_de;
  logic [23:0] s0_rgb;
  bit          m_started, m_locked, m_bad;
  int          m_streak, m_errs, m_pix, m_lines;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    s0_vs = 0; s0_hs = 0; s0_de = 0; s0_rgb = '0; p_vs = 0; p_de = 0;
    m_started = 0; m_locked = 0; m_bad = 0;
    m_streak = 0; m_errs = 0; m_pix = 0; m_lines = 0;
  endtask

  // Expected pack for the sample held in s0 (the one taken one edge earlier)
  task automatic model_tick(output logic [PW-1:0] ep, output logic efe);
    bit fs, ls, le, g, sof;
    logic [XW-1:0] xs;
    logic [YW-1:0] ys;
    logic [23:0]   cs;
    fs = s0_vs && !p_vs;
    ls = s0_de && !p_de;
    le = !s0_de && p_de;
    efe = 1'b0; xs = '0; ys = '0; cs = '0; sof = 0;
    if (le) begin
      if (m_pix != H) m_bad = 1;
      m_lines++;
    end
    if (fs) begin
      if (m_started) begin
        if (!m_bad && m_lines == V) begin
          if (!m_locked) begin
            m_streak++;
            if (m_streak >= LK) m_locked = 1;
          end
        end else begin
          m_streak = 0;
          m_locked = 0;
          efe = 1'b1;
          if (m_errs < 255) m_errs++;
        end
      end else begin
        m_started = 1;
        m_streak = 0;
      end
      m_lines = 0;
      m_bad = 0;
    end
    g = s0_de && m_locked;
    if (s0_de) begin
      if (ls) m_pix = 0;
      if (g) begin
        xs  = XW'(imin(m_pix, H - 1));
        ys  = YW'(imin(m_lines, V - 1));
        cs  = s0_rgb;
        sof = (m_pix == 0) && (m_lines == 0);
      end
      m_pix++;
    end
    ep = {s0_vs, s0_hs, g, cs, xs, ys, sof};
  endtask

  // One clock of stimulus; checks both instances against the model
  task automatic step(input logic r, input logic v, input logic h, input logic d,
                      input logic [23:0] c);
    logic [PW-1:0] ep;
    logic efe;
    rstn = ~r; vs = v; hs = h; de = d; rgb = c;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
      ep = '0;
      efe = 1'b0;
    end else begin
      model_tick(ep, efe);
    end
    chk("cyc_pos", {pack_p, lk_p, fe_p, ec_p}, {ep, m_locked, efe, 8'(m_errs)});
    chk("cyc_neg", {pack_n, lk_n, fe_n, ec_n}, {ep, m_locked, efe, 8'(m_errs)});
    fe_seen  += int'(fe_p);
    sof_seen += int'(pack_p[0]);
    if (!r) begin
      p_vs = s0_vs; p_de = s0_de;
      s0_vs = v; s0_hs = h; s0_de = d; s0_rgb = c;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    idle(2);
  endtask

  task automatic pixels(input int n);
    for (int p = 0; p < n; p++) step(1'b0, 1'b0, 1'b0, 1'b1, 24'($urandom()));
  endtask

  task automatic lines(input int n, input int bidx, input int blen, input int hb);
    for (int l = 0; l < n; l++) begin
      pixels((l == bidx) ? blen : H);
      for (int b = 0; b < hb; b++) step(1'b0, 1'b0, logic'(b == 0), 1'b0, 24'd0);
    end
  endtask

  typedef struct {
    int   nl;
    int   bidx;
    int   blen;
    logic e_lock;
    int   e_err;
    int   e_fe;
    int   e_sof;
  } rec_t;

  rec_t tbl[12];

  initial begin
    // Each record: vs pulse (evaluates previous frame), then nl lines.
    // Expected lock / err_cnt / frame_err pulses are those seen at the pulse.
    tbl[0]  = '{6, -1,  0, 1'b0, 0, 0, 0};
    tbl[1]  = '{6, -1,  0, 1'b0, 0, 0, 0};
    tbl[2]  = '{6, -1,  0, 1'b1, 0, 0, 1};
    tbl[3]  = '{6,  2, 17, 1'b1, 0, 0, 1};
    tbl[4]  = '{6, -1,  0, 1'b0, 1, 1, 0};
    tbl[5]  = '{5, -1,  0, 1'b0, 1, 0, 0};
    tbl[6]  = '{6,  3, 15, 1'b0, 2, 1, 0};
    tbl[7]  = '{6, -1,  0, 1'b0, 3, 1, 0};
    tbl[8]  = '{6, -1,  0, 1'b0, 3, 0, 0};
    tbl[9]  = '{7, -1,  0, 1'b1, 3, 0, 1};
    tbl[10] = '{6, -1,  0, 1'b0, 4, 1, 0};
    tbl[11] = '{6, -1,  0, 1'b0, 4, 0, 0};

    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    chk("reset_pack", 64'(pack_p), 64'd0);
    chk("reset_locked", 64'(lk_p), 64'd0);
    chk("reset_errcnt", 64'(ec_p), 64'd0);
    idle(3);

    for (int i = 0; i < 12; i++) begin
      fe_seen = 0;
      vs_pulse();
      chk("tbl_locked", 64'(lk_p), 64'(tbl[i].e_lock));
      chk("tbl_errcnt", 64'(ec_p), 64'(tbl[i].e_err));
      chk("tbl_fe", 64'(fe_seen), 64'(tbl[i].e_fe));
      sof_seen = 0;
      lines(tbl[i].nl, tbl[i].bidx, tbl[i].blen, 4);
      chk("tbl_sof", 64'(sof_seen), 64'(tbl[i].e_sof));
      $display("rec %0d: lines=%0d locked=%0b err_cnt=%0d fe=%0d sof=%0d",
               i, tbl[i].nl, lk_p, ec_p, fe_seen, sof_seen);
    end

    // Lock again, then a frame whose last line end coincides with the next vs rise
    vs_pulse();
    chk("relock_tbl", 64'(lk_p), 64'd1);
    lines(V - 1, -1, 0, 4);
    pixels(H);
    fe_seen = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
    idle(2);
    chk("fs_le_same_fe", 64'(fe_seen), 64'd0);
    chk("fs_le_same_lock", 64'(lk_p), 64'd1);
    $display("seq fs+le: locked=%0b fe=%0d", lk_p, fe_seen);

    // de held high across a frame start: that line becomes line 0, x continues
    lines(V, -1, 0, 4);
    pixels(4);
    fe_seen = 0;
    sof_seen = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 24'($urandom()));
    step(1'b0, 1'b1, 1'b0, 1'b1, 24'($urandom()));
    pixels(H - 6);
    idle(4);
    lines(V - 1, -1, 0, 4);
    vs_pulse();
    chk("de_cross_fe", 64'(fe_seen), 64'd0);
    chk("de_cross_sof", 64'(sof_seen), 64'd0);
    chk("de_cross_lock", 64'(lk_p), 64'd1);
    $display("seq de across vs: locked=%0b fe=%0d sof=%0d", lk_p, fe_seen, sof_seen);

    // Reset for one clock mid-frame while locked
    lines(2, -1, 0, 4);
    pixels(5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
    chk("midrst_pack", 64'(pack_p), 64'd0);
    chk("midrst_locked", 64'(lk_p), 64'd0);
    chk("midrst_errcnt", 64'(ec_p), 64'd0);
    pixels(H - 5);
    lines(3, -1, 0, 4);
    for (int k = 0; k < 3; k++) begin
      vs_pulse();
      chk("midrst_relock", 64'(lk_p), 64'(k == 2));
      lines(V, -1, 0, 4);
    end
    $display("seq reset mid-frame: locked=%0b err_cnt=%0d", lk_p, ec_p);

    // Randomized frames checked by the per-cycle model
    for (int f = 0; f < 10; f++) begin
      int nl, bidx, blen;
      nl   = V;
      bidx = -1;
      blen = H;
      if ($urandom_range(0, 4) == 0) nl = ($urandom_range(0, 1) == 1) ? V + 1 : V - 1;
      if ($urandom_range(0, 4) == 0) begin
        bidx = int'($urandom_range(0, V - 2));
        blen = ($urandom_range(0, 1) == 1) ? H + 1 : H - 1;
      end
      vs_pulse();
      lines(nl, bidx, blen, int'($urandom_range(1, 5)));
      $display("rand frame %0d: lines=%0d badline=%0d len=%0d locked=%0b err_cnt=%0d",
               f, nl, bidx, blen, lk_p, ec_p);
    end

    // 300 consecutive empty (bad) frames: err_cnt saturates, pulses continue
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
    fe_seen = 0;
    for (int k = 0; k < 301; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0);
      idle(2);
    end
    idle(2);
    chk("sat_errcnt", 64'(ec_p), 64'd255);
    chk("sat_fe_pulses", 64'(fe_seen), 64'd300);
    $display("seq saturation: err_cnt=%0d fe=%0d", ec_p, fe_seen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
